// File: rtl/iir_cfg_pkg.sv
// iir_cfg_pkg
//   Shared constants for the IIR coefficient controller: FSM state codes,
//   coefficient width, default coefficient count and beat-unpacking helpers.
package iir_cfg_pkg;

  localparam int COEF_W       = 16;
  localparam int NUM_COEF_DEF = 12;
  localparam int STATE_W      = 3;

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] COMMIT = 3'd2;
  localparam logic [STATE_W-1:0] SETTLE = 3'd3;
  localparam logic [STATE_W-1:0] RUN    = 3'd4;
  localparam logic [STATE_W-1:0] DRAIN  = 3'd5;

  // A beat carries coef[2k] in the upper half and coef[2k+1] in the lower half.
  function automatic logic [COEF_W-1:0] unpack_hi(input logic [2*COEF_W-1:0] word);
    return word[2*COEF_W-1:COEF_W];
  endfunction

  function automatic logic [COEF_W-1:0] unpack_lo(input logic [2*COEF_W-1:0] word);
    return word[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// iir_coef_bank
//   Shadow and active coefficient register banks. Beats are written pairwise
//   into the shadow bank; a commit copies the whole shadow bank to the active
//   bank, which is the only thing the datapath ever sees.
// Ports
//   clk, rst_n   clock, async active-low reset (both banks cleared)
//   wr_en        write one beat into the shadow bank
//   wr_idx       beat index k -> shadow[2k], shadow[2k+1]
//   wr_data      packed beat {coef[2k], coef[2k+1]}
//   commit       copy shadow -> active
//   coef_flat    active bank, coef[i] at [COEF_W*i +: COEF_W]
module iir_coef_bank
  import iir_cfg_pkg::*;
#(
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int IDX_W    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [2*COEF_W-1:0]          wr_data,
  input  logic                         commit,
  output logic [NUM_COEF*COEF_W-1:0]   coef_flat
);

  localparam int NW = NUM_COEF / 2;

  logic [COEF_W-1:0] shadow [NUM_COEF];
  logic [COEF_W-1:0] active [NUM_COEF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_en && (wr_idx == IDX_W'(k))) begin
          shadow[2*k]   <= unpack_hi(wr_data);
          shadow[2*k+1] <= unpack_lo(wr_data);
        end
      end
      if (commit) begin
        for (int i = 0; i < NUM_COEF; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_COEF; g++) begin : g_flat
    assign coef_flat[g*COEF_W +: COEF_W] = active[g];
  end

endmodule

// File: rtl/iir_coef_ctrl.sv
// iir_coef_ctrl
//   Coefficient load/commit sequencer for the direct-form IIR datapath.
//   Receives coefficient frames on AXI-Stream, checks the frame length against
//   tlast, commits good frames to the active bank and then holds the filter
//   disabled for SETTLE_CYC cycles before re-enabling it.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   s_axis_tdata/tvalid/tlast      coefficient stream, two coefficients per beat
//   s_axis_tready                  stream ready (low in COMMIT/SETTLE and in reset)
//   coef_flat                      active coefficient bank
//   filt_en                        registered datapath enable
//   cfg_done                       one-cycle pulse when the filter comes back up
//   cfg_err / err_clr              sticky frame-length error and its clear
//   state_moni / word_cnt_moni     debug views of FSM state and beat count
//
// state  | meaning
// IDLE   | no commit yet, filter off, waiting for first beat
// LOAD   | mid-frame, filling the shadow bank
// COMMIT | one cycle, shadow -> active, filter off
// SETTLE | filter held off while the settle timer runs down
// RUN    | filter on, waiting for a new frame
// DRAIN  | frame too long, discarding beats until tlast
module iir_coef_ctrl
  import iir_cfg_pkg::*;
#(
  parameter int NUM_COEF   = NUM_COEF_DEF,
  parameter int SETTLE_CYC = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2*COEF_W-1:0]        s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [NUM_COEF*COEF_W-1:0] coef_flat,
  output logic                       filt_en,
  output logic                       cfg_done,
  output logic                       cfg_err,
  input  logic                       err_clr,
  output logic [2:0]                 state_moni,
  output logic [3:0]                 word_cnt_moni
);

  localparam int NW    = NUM_COEF / 2;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] origin;
  logic [3:0]         word_cnt;
  logic [SC_W-1:0]    settle_cnt;
  logic               ran_once;
  logic               beat;
  logic               last_word;
  logic               err_set;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;

  assign s_axis_tready = rst_n & ((state == IDLE) || (state == RUN) ||
                                  (state == LOAD) || (state == DRAIN));
  assign beat      = s_axis_tvalid & s_axis_tready;
  assign origin    = ran_once ? RUN : IDLE;
  assign last_word = (word_cnt == 4'(NW - 1));

  // Frame-length errors: tlast too early (IDLE/RUN/LOAD) or after overrun (DRAIN).
  always_comb begin
    err_set = 1'b0;
    if (beat && s_axis_tlast) begin
      case (state)
        IDLE, RUN: err_set = (NW != 1);
        LOAD:      err_set = !last_word;
        DRAIN:     err_set = 1'b1;
        default:   err_set = 1'b0;
      endcase
    end
  end

  // Beats in DRAIN are dropped; the first beat of a frame always lands at index 0.
  assign wr_en  = beat && ((state == IDLE) || (state == RUN) || (state == LOAD));
  assign wr_idx = (state == LOAD) ? word_cnt[IDX_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      settle_cnt <= '0;
      ran_once   <= 1'b0;
      filt_en    <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;

      if (err_set) begin
        cfg_err <= 1'b1;
      end else if (err_clr) begin
        cfg_err <= 1'b0;
      end

      case (state)
        IDLE, RUN: begin
          if (beat) begin
            word_cnt <= 4'd1;
            if (s_axis_tlast) begin
              if (NW == 1) begin
                state <= COMMIT;
              end else begin
                state    <= origin;
                word_cnt <= '0;
              end
            end else begin
              state <= (NW == 1) ? DRAIN : LOAD;
            end
          end
        end

        LOAD: begin
          if (beat) begin
            word_cnt <= word_cnt + 4'd1;
            if (last_word) begin
              state <= s_axis_tlast ? COMMIT : DRAIN;
            end else if (s_axis_tlast) begin
              state    <= origin;
              word_cnt <= '0;
            end
          end
        end

        DRAIN: begin
          if (beat) begin
            if (s_axis_tlast) begin
              state    <= origin;
              word_cnt <= '0;
            end else if (word_cnt != 4'hF) begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end

        COMMIT: begin
          filt_en    <= 1'b0;
          settle_cnt <= SC_W'(SETTLE_CYC - 1);
          word_cnt   <= '0;
          ran_once   <= 1'b1;
          state      <= SETTLE;
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            state    <= RUN;
            filt_en  <= 1'b1;
            cfg_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  iir_coef_bank #(
    .NUM_COEF (NUM_COEF),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (s_axis_tdata),
    .commit    (state == COMMIT),
    .coef_flat (coef_flat)
  );

  assign state_moni    = state;
  assign word_cnt_moni = word_cnt;

endmodule

// File: tb/tb_iir_coef_ctrl.sv
module tb_iir_coef_ctrl;

  localparam int NUM_COEF   = 12;
  localparam int SETTLE_CYC = 14;
  localparam int NW         = NUM_COEF / 2;
  localparam int FW         = NUM_COEF * 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [FW-1:0] coef_flat;
  logic          filt_en;
  logic          cfg_done;
  logic          cfg_err;
  logic          err_clr = 1'b0;
  logic [2:0]    state_moni;
  logic [3:0]    word_cnt_moni;

  iir_coef_ctrl #(
    .NUM_COEF   (NUM_COEF),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .coef_flat     (coef_flat),
    .filt_en       (filt_en),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .err_clr       (err_clr),
    .state_moni    (state_moni),
    .word_cnt_moni (word_cnt_moni)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what the active bank and flags should hold
  logic [15:0] exp_coef [NUM_COEF];
  logic        exp_err  = 1'b0;
  logic        ran_once = 1'b0;
  logic [31:0] fb [16];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NUM_COEF; i++) f[16*i +: 16] = exp_coef[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_COEF; i++) exp_coef[i] = '0;
    exp_err  = 1'b0;
    ran_once = 1'b0;
  endtask

  // A frame is good iff its tlast lands exactly on beat NW.
  task automatic model_apply(input int len);
    if (len == NW) begin
      for (int b = 0; b < NW; b++) begin
        exp_coef[2*b]   = fb[b][31:16];
        exp_coef[2*b+1] = fb[b][15:0];
      end
      ran_once = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Returns with the beat accepted at edge acc, sampled #1 after it.
  task automatic send_beat(input logic [31:0] d, input logic last, output int acc);
    int budget;
    budget = 200;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    while (!s_axis_tready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("beat_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    acc = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int max_gap, input logic fixed,
                            output int first_e, output int last_e);
    logic [31:0] d;
    int e;
    first_e = 0;
    last_e  = 0;
    for (int b = 0; b < len; b++) begin
      d = fixed ? {16'(2*b+1), 16'(2*b+2)} : $urandom;
      if (b < 16) fb[b] = d;
      repeat ($urandom_range(max_gap, 0)) @(posedge clk);
      send_beat(d, (b == len - 1), e);
      if (b == 0) first_e = e;
    end
    last_e = e;
  endtask

  // Called #1 after the edge that accepted the last beat of a good frame.
  task automatic chk_commit(input logic [FW-1:0] old_flat, input logic was_run);
    int filt_lo, rdy_lo, done_n, done_at;
    filt_lo = 0; rdy_lo = 0; done_n = 0; done_at = -1;
    chk("commit_coef_hold", coef_flat, old_flat);
    chk("commit_en_hold", filt_en, was_run);
    for (int n = 0; n <= SETTLE_CYC + 3; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n == 1) chk("coef_update", coef_flat, model_flat());
      if (n >= 1 && !filt_en) filt_lo++;
      if (!s_axis_tready) rdy_lo++;
      if (cfg_done) begin
        done_n++;
        done_at = n;
      end
    end
    chk("settle_len", filt_lo, SETTLE_CYC);
    chk("tready_low_len", rdy_lo, SETTLE_CYC + 1);
    chk("done_pulses", done_n, 1);
    chk("done_at", done_at, SETTLE_CYC + 1);
    chk("run_state", state_moni, ST_RUN);
    chk("filt_en_run", filt_en, 1'b1);
    chk("err_after_good", cfg_err, exp_err);
  endtask

  task automatic finish_frame(input int len);
    logic [FW-1:0] old;
    logic          was_run;
    old     = model_flat();
    was_run = ran_once;
    model_apply(len);
    if (len == NW) begin
      chk_commit(old, was_run);
    end else begin
      chk("bad_err", cfg_err, 1'b1);
      chk("bad_coef", coef_flat, old);
      chk("bad_en", filt_en, was_run);
      chk("bad_state", state_moni, was_run ? ST_RUN : ST_IDLE);
      chk("bad_wcnt", word_cnt_moni, 4'd0);
      chk("bad_rdy", s_axis_tready, 1'b1);
    end
  endtask

  task automatic run_frame(input int len, input int max_gap, input logic fixed);
    int fe, le;
    send_frame(len, max_gap, fixed, fe, le);
    finish_frame(len);
  endtask

  task automatic pulse_clr();
    chk("err_model", cfg_err, exp_err);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", cfg_err, 1'b0);
  endtask

  task automatic chk_seq();
    for (int i = 0; i < NUM_COEF; i++) chk("coef_seq", coef_flat[16*i +: 16], 16'(i + 1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, s_axis_tready, 1'b0);
    chk({tag, "_coef"}, coef_flat, {FW{1'b0}});
    chk({tag, "_en"}, filt_en, 1'b0);
    chk({tag, "_done"}, cfg_done, 1'b0);
    chk({tag, "_err"}, cfg_err, 1'b0);
    chk({tag, "_state"}, state_moni, ST_IDLE);
    chk({tag, "_wcnt"}, word_cnt_moni, 4'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fa, la, fb2, lb, e;
    model_reset();

    #23;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_rdy", s_axis_tready, 1'b1);

    // Good frame from IDLE with known data
    run_frame(NW, 0, 1'b1);
    chk_seq();

    // Short frame while running
    run_frame(3, 0, 1'b0);
    // Long frame: extra beats drained, no commit
    run_frame(8, 1, 1'b0);
    pulse_clr();

    // Gapped tvalid
    run_frame(NW, 5, 1'b0);

    // Set wins over a simultaneous clear
    err_clr = 1'b1;
    run_frame(2, 0, 1'b0);
    err_clr = 1'b0;
    pulse_clr();

    // Reset in the middle of a frame
    for (int b = 0; b < 4; b++) send_beat($urandom, 1'b0, e);
    chk("mid_wcnt", word_cnt_moni, 4'd4);
    chk("mid_state", state_moni, ST_LOAD);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(NW, 0, 1'b1);
    chk_seq();

    // Back-to-back: second frame stalls through COMMIT/SETTLE
    send_frame(NW, 0, 1'b0, fa, la);
    model_apply(NW);
    send_frame(NW, 0, 1'b0, fb2, lb);
    chk("b2b_stall", fb2, la + SETTLE_CYC + 2);
    finish_frame(NW);

    // Randomized frames
    for (int r = 0; r < 16; r++) begin
      int len;
      len = ($urandom_range(1, 0) == 1) ? NW : int'($urandom_range(8, 1));
      run_frame(len, $urandom_range(3, 0), 1'b0);
      if ($urandom_range(2, 0) == 0) pulse_clr();
    end
    chk("final_coef", coef_flat, model_flat());
    chk("final_err", cfg_err, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
